// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stream adapter:
// state encoding, default sizes and the pointer-width helper.
package fifo_rd_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_SKID_DEPTH = 2;

    // Adapter states (IDLE, RUN, FLUSH) kept as plain constants so the
    // encoding matches older blocks that compare against raw codes.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // Bits needed to index 'depth' entries (ceil(log2(depth)), minimum 1).
    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Small circular output buffer for the read-side adapter.
// Push/pop/clear with an occupancy count and a registered-storage head word.
// Pointers wrap naturally because DEPTH is a power of two; clear wins over
// push and pop in the same cycle. Storage itself carries no reset.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_SKID_DEPTH,
    localparam int PW        = ptr_width(DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [PW:0]           occ,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    // Pointer and occupancy bookkeeping; a clear empties the buffer outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Word storage; a push that coincides with clear is discarded
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: drives rd_en into a synchronous FIFO with a one-cycle
// registered read latency and re-presents the words as a valid/ready stream
// at one word per cycle through a small skid buffer. Supports a flush mode
// that drains and discards the FIFO, and a sticky underflow error flag.
// Optional build macro FIFO_RD_STATS_EN adds saturating pop and stall
// counters with a synchronous clear.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SKID_DEPTH = DEFAULT_SKID_DEPTH,
    parameter int CNT_WIDTH  = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  err_underflow,
    input  logic                  err_clr
`ifdef FIFO_RD_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  stall_count
`endif
);

    localparam int PW = ptr_width(SKID_DEPTH);
    localparam logic [PW+1:0] DEPTH_L = (PW+2)'(SKID_DEPTH);

    if (SKID_DEPTH < 2 || (SKID_DEPTH & (SKID_DEPTH - 1)) != 0 || CNT_WIDTH < 1) begin : g_param_check
        $error("fifo_rd_stream: SKID_DEPTH must be a power of two >= 2 and CNT_WIDTH >= 1");
    end

    state_t                state;
    state_t                state_next;
    logic                  inflight;
    logic [PW:0]           occ;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] head;
    logic                  pop;
    logic                  push;
    logic                  flush_entry;
    logic                  flush_exit;
    logic [PW+1:0]         credit_sum;

    assign flush_entry = flush && (state != ST_FLUSH);
    assign flush_exit  = (state == ST_FLUSH) && fifo_empty && !inflight;

    // Stream side: nothing is offered while flushing; data reads as zero
    // whenever it is not valid so no stale word is ever visible.
    assign m_valid = !buf_empty && (state != ST_FLUSH);
    assign m_data  = m_valid ? head : '0;
    assign pop     = m_valid && m_ready;

    // The word returned by last cycle's read lands now; dropped in FLUSH.
    assign push = inflight && (state != ST_FLUSH);

    // Words already owed to the buffer after this cycle's pop.
    assign credit_sum = {1'b0, occ} + {{(PW+1){1'b0}}, inflight} - {{(PW+1){1'b0}}, pop};

    // Read strobe: credit-limited in RUN (stops at once when enable drops),
    // unconditional drain in FLUSH, idle otherwise
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            ST_RUN:   fifo_rd_en = enable && !fifo_empty && (credit_sum < DEPTH_L);
            ST_FLUSH: fifo_rd_en = !fifo_empty;
            default:  fifo_rd_en = 1'b0;
        endcase
    end

    fifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_entry),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .empty     (buf_empty),
        .head      (head)
    );

    // Next-state selection; a flush request overrides everything but is
    // ignored once already flushing
    always_comb begin
        state_next = state;
        if (flush_entry) begin
            state_next = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:  if (enable)     state_next = ST_RUN;
                ST_RUN:   if (!enable)    state_next = ST_IDLE;
                ST_FLUSH: if (flush_exit) state_next = ST_IDLE;
                default:                  state_next = ST_IDLE;
            endcase
        end
    end

    // State and read-pipeline tracking; reset drops any word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fifo_rd_en;
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              err_underflow <= 1'b0;
        else if (fifo_underflow) err_underflow <= 1'b1;
        else if (err_clr)        err_underflow <= 1'b0;
    end

    assign busy       = (state != ST_IDLE) || inflight || !buf_empty;
    assign flush_done = flush_exit;

`ifdef FIFO_RD_STATS_EN
    // Saturating counters of accepted words and back-pressured cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count  <= '0;
            stall_count <= '0;
        end else if (stats_clr) begin
            word_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (word_count != '1))                     word_count  <= word_count + 1'b1;
            if (m_valid && !m_ready && (stall_count != '1))    stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural FIFO plus an in-order word queue
// as the reference; directed scenarios followed by a randomized phase.
module tb_fifo_rd_stream;

    localparam int DW = 16;
    localparam int SD = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_underflow;
    logic          fifo_rd_en;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          busy;
    logic          flush_done;
    logic          err_underflow;
    logic          err_clr;
`ifdef FIFO_RD_STATS_EN
    logic          stats_clr;
    logic [CW-1:0] word_count;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] m_wc;
    logic [CW-1:0] m_sc;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .SKID_DEPTH (SD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_ready        (m_ready),
        .busy           (busy),
        .flush_done     (flush_done),
        .err_underflow  (err_underflow),
        .err_clr        (err_clr)
`ifdef FIFO_RD_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .word_count     (word_count),
        .stall_count    (stall_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state: FIFO contents, words owed to the stream in order,
    // and the adapter's mode as implied by the rules.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] expq[$];
    bit            m_flush, m_run, m_infl, m_kept, m_err;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    int            cyc, rd_cnt, pop_cnt, done_cnt;
    int            first_rd, first_vld, first_pop, last_pop;
    logic [DW-1:0] first_pop_data;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, req, cyc);
        end
    endtask

    task automatic clear_marks();
        rd_cnt = 0; pop_cnt = 0; done_cnt = 0;
        first_rd = -1; first_vld = -1; first_pop = -1; last_pop = -1;
    endtask

    // One clock: check outputs at the falling edge, then advance the model
    task automatic cycle();
        bit rd, pop, exp_rd, exp_vld, exp_pop, exp_done, keep, enter;
        int avail;
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
        rd      = fifo_rd_en;
        pop     = m_valid && m_ready;
        avail   = expq.size() - (m_kept ? 1 : 0);
        exp_vld = !m_flush && (avail > 0);
        exp_pop = exp_vld && m_ready;
        if (m_flush)               exp_rd = (fq.size() != 0);
        else if (m_run && enable)  exp_rd = (fq.size() != 0) && ((expq.size() - (exp_pop ? 1 : 0)) < SD);
        else                       exp_rd = 1'b0;
        exp_done = m_flush && (fq.size() == 0) && !m_infl;
        check_eq("m_valid", 32'(m_valid), 32'(exp_vld));
        check_eq("rd_en", 32'(rd), 32'(exp_rd));
        check_eq("flush_done", 32'(flush_done), 32'(exp_done));
        check_eq("err_underflow", 32'(err_underflow), 32'(m_err));
        if (prev_stall && !m_flush) begin
            check_eq("stall_valid", 32'(m_valid), 32'd1);
            check_eq("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (pop) begin
            if (avail <= 0) check_eq("pop_nothing_owed", 32'd1, 32'd0);
            else begin
                if (first_pop < 0) first_pop_data = m_data;
                check_eq("m_data", 32'(m_data), 32'(expq.pop_front()));
            end
        end
`ifdef FIFO_RD_STATS_EN
        check_eq("word_count", 32'(word_count), 32'(m_wc));
        check_eq("stall_count", 32'(stall_count), 32'(m_sc));
`endif
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (rd) rd_cnt++;
        if (flush_done) done_cnt++;
        if (rd && first_rd < 0) first_rd = cyc;
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (pop) begin
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        m_err = fifo_underflow ? 1'b1 : (err_clr ? 1'b0 : m_err);
`ifdef FIFO_RD_STATS_EN
        if (stats_clr) begin m_wc = '0; m_sc = '0; end
        else begin
            if (pop && m_wc != '1) m_wc = m_wc + 1'b1;
            if (m_valid && !m_ready && m_sc != '1) m_sc = m_sc + 1'b1;
        end
`endif
        enter = flush && !m_flush;
        keep  = rd && !m_flush && !flush && (fq.size() != 0);
        if (enter) expq.delete();
        if (rd && fq.size() != 0) begin
            fifo_data = fq.pop_front();
            if (keep) expq.push_back(fifo_data);
        end
        if (enter) begin
            m_flush = 1'b1; m_run = 1'b0;
        end else if (m_flush) begin
            if (exp_done) begin m_flush = 1'b0; m_run = 1'b0; end
        end else begin
            m_run = enable;
        end
        m_kept = keep;
        m_infl = rd;
        if (!m_flush) check_eq("owed_le_depth", 32'(expq.size() <= SD), 32'd1);
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic model_reset();
        expq.delete();
        m_flush = 0; m_run = 0; m_infl = 0; m_kept = 0; m_err = 0;
        prev_stall = 0;
`ifdef FIFO_RD_STATS_EN
        m_wc = '0; m_sc = '0;
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check_eq({tag, "_m_data"}, 32'(m_data), 32'd0);
        check_eq({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_flush_done"}, 32'(flush_done), 32'd0);
        check_eq({tag, "_err"}, 32'(err_underflow), 32'd0);
    endtask

    // Run with enable and ready high until everything owed has come out
    task automatic drain(input string tag);
        int n;
        enable = 1; m_ready = 1; flush = 0;
        n = 0;
        while ((fq.size() != 0 || expq.size() != 0) && n < 200) begin
            cycle();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(expq.size() + fq.size()), 32'd0);
        enable = 0;
        cycle(); cycle();
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
        fifo_empty = (fq.size() == 0);
    endtask

    initial begin
        logic [DW-1:0] nxt;
        int n;
        rst_n = 0; enable = 0; flush = 0; fifo_empty = 1; fifo_data = '0;
        fifo_underflow = 0; m_ready = 0; err_clr = 0;
`ifdef FIFO_RD_STATS_EN
        stats_clr = 0;
`endif
        cyc = 0;
        model_reset();
        clear_marks();
        #1;
        check_outputs_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;

        // Streaming at full rate
        load(8, 16'h0001);
        enable = 1; m_ready = 1;
        clear_marks();
        for (int i = 0; i < 14; i++) cycle();
        check_eq("t1_latency", 32'(first_vld - first_rd), 32'd2);
        check_eq("t1_pops", 32'(pop_cnt), 32'd8);
        check_eq("t1_no_gap", 32'(last_pop - first_pop), 32'd7);
        check_eq("t1_first_word", 32'(first_pop_data), 32'h0001);
        drain("t1");

        // Alternating back-pressure
        load(8, 16'h0101);
        enable = 1;
        clear_marks();
        for (int i = 0; i < 24; i++) begin
            m_ready = i[0] ? 1'b0 : 1'b1;
            cycle();
        end
        check_eq("t2_pops", 32'(pop_cnt), 32'd8);
        drain("t2");

        // Long stall: only the buffer's worth of reads may be issued
        load(8, 16'h0201);
        enable = 1; m_ready = 0;
        clear_marks();
        for (int i = 0; i < 10; i++) cycle();
        check_eq("t3_rd_pulses", 32'(rd_cnt), 32'd2);
        check_eq("t3_rd_idle", 32'(fifo_rd_en), 32'd0);
        m_ready = 1;
        clear_marks();
        for (int i = 0; i < 12; i++) cycle();
        check_eq("t3_pops", 32'(pop_cnt), 32'd8);
        check_eq("t3_no_gap", 32'(last_pop - first_pop), 32'd7);
        drain("t3");

        // Flush with one word buffered and five still in the FIFO
        load(1, 16'h0A01);
        enable = 1; m_ready = 0;
        for (int i = 0; i < 4; i++) cycle();
        enable = 0;
        cycle();
        check_eq("t4_buffered", 32'(m_valid), 32'd1);
        load(5, 16'h0B01);
        clear_marks();
        flush = 1;
        cycle();
        flush = 0; m_ready = 1;
        check_eq("t4_valid_drop", 32'(m_valid), 32'd0);
        n = 0;
        while (done_cnt == 0 && n < 20) begin cycle(); n++; end
        cycle(); cycle();
        check_eq("t4_reads", 32'(rd_cnt), 32'd5);
        check_eq("t4_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("t4_emitted", 32'(pop_cnt), 32'd0);
        check_eq("t4_idle", 32'(busy), 32'd0);

        // Sticky underflow error
        fifo_underflow = 1; cycle();
        fifo_underflow = 0; cycle(); cycle();
        check_eq("t5_err_held", 32'(err_underflow), 32'd1);
        fifo_underflow = 1; err_clr = 1; cycle();
        fifo_underflow = 0; err_clr = 0;
        check_eq("t5_set_wins", 32'(err_underflow), 32'd1);
        err_clr = 1; cycle();
        err_clr = 0;
        check_eq("t5_cleared", 32'(err_underflow), 32'd0);
        cycle();

        // Asynchronous reset in the middle of a transfer
        load(8, 16'h0C01);
        enable = 1; m_ready = 0;
        for (int i = 0; i < 3; i++) cycle();
        m_ready = 1;
        cycle();
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check_outputs_zero("t6");
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        nxt = fq[0];
        clear_marks();
        drain("t6");
        check_eq("t6_resume_word", 32'(first_pop_data), 32'(nxt));

        // Randomized traffic, back-pressure, flushes and error events
        for (int i = 0; i < 1500; i++) begin
            enable         = ($urandom_range(0, 9) != 0);
            m_ready        = ($urandom_range(0, 2) != 0);
            flush          = ($urandom_range(0, 79) == 0);
            fifo_underflow = ($urandom_range(0, 59) == 0);
            err_clr        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) fq.push_back(DW'($urandom));
            cycle();
        end
        flush = 0; fifo_underflow = 0; err_clr = 0;
        n = 0;
        while (m_flush && n < 100) begin cycle(); n++; end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
